// File: rtl/fpro_bus_arbiter_if.sv
// fpro_bus_arbiter_if: two-master request/ack ports plus the shared FPro MMIO bus
interface fpro_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              m0_req, m1_req, m0_wr, m1_wr, m0_ack, m1_ack;
  logic [ADDR_W-1:0] m0_addr, m1_addr, fp_addr;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
  logic [DATA_W-1:0] fp_wr_data, fp_rd_data;
  logic              fp_mmio_cs, fp_wr, fp_rd, busy;
  logic [1:0]        grant;
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wr_data, m1_wr_data, fp_rd_data,
    output m0_ack, m1_ack, m0_rd_data, m1_rd_data, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
           grant, busy
  );
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wr_data, m1_wr_data, fp_rd_data,
    input  m0_ack, m1_ack, m0_rd_data, m1_rd_data, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
           grant, busy
  );
endinterface

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: round-robin two-master arbiter driving one FPro MMIO bus cycle per grant
module fpro_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               reset,
  fpro_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t            state, state_nx;
  logic              xfer, done, any_req, win, last_winner, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rd0_q, rd1_q;
  assign any_req = bus.m0_req | bus.m1_req;
  assign win     = (bus.m0_req & bus.m1_req) ? ~last_winner : bus.m1_req;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // next state and state decodes; XFER and DONE each last exactly one cycle
  always_comb begin
    xfer     = state == XFER;
    done     = state == DONE;
    state_nx = xfer ? DONE : (!done && any_req) ? XFER : IDLE;
  end
  // last_winner doubles as the owner of the in-flight transaction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_winner <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last_winner <= win;
        wr_q        <= win ? bus.m1_wr : bus.m0_wr;
        addr_q      <= win ? bus.m1_addr : bus.m0_addr;
        data_q      <= win ? bus.m1_wr_data : bus.m0_wr_data;
      end
      if (xfer && !wr_q && !last_winner) rd0_q <= bus.fp_rd_data;
      if (xfer && !wr_q && last_winner)  rd1_q <= bus.fp_rd_data;
    end
  assign bus.fp_mmio_cs = xfer;
  assign bus.fp_wr      = xfer & wr_q;
  assign bus.fp_rd      = xfer & ~wr_q;
  assign bus.fp_addr    = xfer ? addr_q : '0;
  assign bus.fp_wr_data = xfer ? data_q : '0;
  assign bus.m0_ack     = done & ~last_winner;
  assign bus.m1_ack     = done & last_winner;
  assign bus.m0_rd_data = rd0_q;
  assign bus.m1_rd_data = rd1_q;
  assign bus.busy       = xfer | done;
  assign bus.grant      = (xfer | done) ? {last_winner, ~last_winner} : 2'b00;
endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// tb_fpro_bus_arbiter: vector table, corner sequences and randomized traffic against a transaction-timeline model
module tb_fpro_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  fpro_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return (a == 21'h00204) ? 32'h12345678 : ({a[10:0], a} ^ 32'hA5A50F0F);
  endfunction
  assign bus.fp_rd_data = slave_rd(bus.fp_addr);
  logic [7:0] ctl;
  assign ctl = {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd, bus.m0_ack, bus.m1_ack, bus.grant, bus.busy};
  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [7:0] ctl; logic [AW-1:0] addr; logic [DW-1:0] wd, rd1;
  } vec_t;
  vec_t tbl[12];
  logic            r[2], wv[2];
  logic [AW-1:0]   av[2];
  logic [DW-1:0]   dv[2];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_m(input int m, input logic rq, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      bus.m0_req = rq; bus.m0_wr = w; bus.m0_addr = a; bus.m0_wr_data = d;
    end else begin
      bus.m1_req = rq; bus.m1_wr = w; bus.m1_addr = a; bus.m1_wr_data = d;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic rnd_fields(input int m);
    wv[m] = 1'($urandom_range(1, 0));
    av[m] = AW'($urandom);
    dv[m] = $urandom;
  endtask
  function automatic vec_t row(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [7:0] c, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                               input logic [DW-1:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ctl = c; v.addr = ad; v.wd = wd; v.rd1 = rd1;
    return v;
  endfunction
  initial begin
    int            next_idle, s, ncs, nack, last_cs, n, a0c, a1c;
    logic          last, tw, twr, xf, dn;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    logic [DW-1:0] rd_exp[2];
    logic          inflight[2];
    logic [AW-1:0] seen[4];
    int            own[6];
    tbl[0]  = row(1'b1, 1'b1, 21'h10, 32'hDEADBEEF, 1'b0, 1'b0, 21'h0,   32'h0,      8'b1100_0011, 21'h10, 32'hDEADBEEF, 32'h0);
    tbl[1]  = row(1'b1, 1'b1, 21'h10, 32'hDEADBEEF, 1'b0, 1'b0, 21'h0,   32'h0,      8'b0001_0011, 21'h0,  32'h0,        32'h0);
    tbl[2]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b0, 1'b0, 21'h0,   32'h0,      8'b0000_0000, 21'h0,  32'h0,        32'h0);
    tbl[3]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b1, 1'b0, 21'h204, 32'h0,      8'b1010_0101, 21'h204,32'h0,        32'h0);
    tbl[4]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b1, 1'b0, 21'h204, 32'h0,      8'b0000_1101, 21'h0,  32'h0,        32'h12345678);
    tbl[5]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b0, 1'b0, 21'h0,   32'h0,      8'b0000_0000, 21'h0,  32'h0,        32'h12345678);
    tbl[6]  = row(1'b1, 1'b1, 21'h30, 32'h11111111, 1'b1, 1'b1, 21'h40,  32'h22222222, 8'b1100_0011, 21'h30, 32'h11111111, 32'h12345678);
    tbl[7]  = row(1'b1, 1'b1, 21'h30, 32'h11111111, 1'b1, 1'b1, 21'h40,  32'h22222222, 8'b0001_0011, 21'h0,  32'h0,        32'h12345678);
    tbl[8]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b1, 1'b1, 21'h40,  32'h22222222, 8'b0000_0000, 21'h0,  32'h0,        32'h12345678);
    tbl[9]  = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b1, 1'b1, 21'h40,  32'h22222222, 8'b1100_0101, 21'h40, 32'h22222222, 32'h12345678);
    tbl[10] = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b1, 1'b1, 21'h40,  32'h22222222, 8'b0000_1101, 21'h0,  32'h0,        32'h12345678);
    tbl[11] = row(1'b0, 1'b0, 21'h0,  32'h0,        1'b0, 1'b0, 21'h0,   32'h0,      8'b0000_0000, 21'h0,  32'h0,        32'h12345678);
    do_reset();
    @(negedge clk);
    check("reset.ctl", 64'(ctl), 64'h0);
    check("reset.addr", 64'(bus.fp_addr), 64'h0);
    check("reset.wd", 64'(bus.fp_wr_data), 64'h0);
    check("reset.rd0", 64'(bus.m0_rd_data), 64'h0);
    check("reset.rd1", 64'(bus.m1_rd_data), 64'h0);
    for (int i = 0; i < 12; i++) begin
      set_m(0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      set_m(1, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl[%0d].ctl", i), 64'(ctl), 64'(tbl[i].ctl));
      check($sformatf("tbl[%0d].addr", i), 64'(bus.fp_addr), 64'(tbl[i].addr));
      check($sformatf("tbl[%0d].wd", i), 64'(bus.fp_wr_data), 64'(tbl[i].wd));
      check($sformatf("tbl[%0d].rd0", i), 64'(bus.m0_rd_data), 64'h0);
      check($sformatf("tbl[%0d].rd1", i), 64'(bus.m1_rd_data), 64'(tbl[i].rd1));
    end
    set_m(1, 1'b1, 1'b0, 21'h204, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst.xfer", 64'(ctl), 64'(8'b1010_0101));
    #2 reset = 1'b1;
    #1;
    check("rst.async_ctl", 64'(ctl), 64'h0);
    check("rst.async_addr", 64'(bus.fp_addr), 64'h0);
    check("rst.async_rd1", 64'(bus.m1_rd_data), 64'h0);
    set_m(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst.no_ack", 64'(ctl), 64'h0);
    end
    set_m(0, 1'b1, 1'b1, 21'h50, 32'h5);
    set_m(1, 1'b1, 1'b0, 21'h60, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst.tie_ctl", 64'(ctl), 64'(8'b1100_0011));
    check("rst.tie_addr", 64'(bus.fp_addr), 64'h50);
    do_reset();
    ncs = 0; nack = 0; last_cs = -1;
    for (int i = 0; i < 4; i++) seen[i] = '0;
    set_m(0, 1'b1, 1'b1, 21'h100, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.fp_mmio_cs) begin
        if (ncs < 4) seen[ncs] = bus.fp_addr;
        if (ncs > 0) check("b2b.gap", 64'(c - last_cs), 64'd3);
        last_cs = c;
        ncs++;
      end
      check("b2b.m1_ack", 64'(bus.m1_ack), 64'h0);
      if (bus.m0_ack) begin
        nack++;
        set_m(0, nack < 4, 1'b1, AW'(32'h100 + 32'(nack) * 4), 32'(nack));
      end
    end
    check("b2b.n_cs", 64'(ncs), 64'd4);
    check("b2b.n_ack", 64'(nack), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b.addr%0d", i), 64'(seen[i]), 64'(32'h100 + 32'(i) * 4));
    do_reset();
    n = 0; a0c = -1; a1c = -1;
    for (int i = 0; i < 6; i++) own[i] = -1;
    set_m(0, 1'b1, 1'b1, 21'h1000, 32'h0);
    set_m(1, 1'b1, 1'b1, 21'h2000, 32'h0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.fp_mmio_cs && n < 6) begin
        own[n] = (bus.grant == 2'b10) ? 1 : 0;
        n++;
      end
      if (bus.m0_ack) begin
        if (a0c >= 0) check("cont.m0_period", 64'(c - a0c), 64'd6);
        a0c = c;
        set_m(0, 1'b1, 1'b1, AW'(32'h1000 + 32'(c)), 32'(c));
      end
      if (bus.m1_ack) begin
        if (a1c >= 0) check("cont.m1_period", 64'(c - a1c), 64'd6);
        a1c = c;
        set_m(1, 1'b1, 1'b1, AW'(32'h2000 + 32'(c)), 32'(c));
      end
    end
    for (int i = 0; i < 6; i++) check($sformatf("cont.owner%0d", i), 64'(own[i]), 64'(i % 2));
    do_reset();
    for (int m = 0; m < 2; m++) begin
      r[m] = 1'b0; wv[m] = 1'b0; av[m] = '0; dv[m] = '0;
      rd_exp[m] = '0; inflight[m] = 1'b0;
    end
    next_idle = 0; s = -10; last = 1'b1; tw = 1'b0; twr = 1'b1; ta = '0; td = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (c >= next_idle && (r[0] || r[1])) begin
        tw = (r[0] && r[1]) ? !last : r[1];
        last = tw; s = c; next_idle = c + 3;
        twr = wv[tw]; ta = av[tw]; td = dv[tw];
        inflight[tw] = 1'b1;
      end
      if (c == s + 1 && !twr) rd_exp[tw] = slave_rd(ta);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (c == s + 2 && m == 32'(tw)) begin
          inflight[m] = 1'b0;
          r[m] = 1'($urandom_range(1, 0));
          rnd_fields(m);
        end else if (!r[m]) begin
          r[m] = ($urandom_range(2, 0) == 0);
          rnd_fields(m);
        end else if (!inflight[m] && $urandom_range(3, 0) == 0) begin
          rnd_fields(m);
        end
      end
      set_m(0, r[0], wv[0], av[0], dv[0]);
      set_m(1, r[1], wv[1], av[1], dv[1]);
      @(negedge clk);
      xf = (c == s);
      dn = (c == s + 1);
      check("rnd.ctl", 64'(ctl), 64'({xf, xf && twr, xf && !twr, dn && !tw, dn && tw,
                                      (xf || dn) && tw, (xf || dn) && !tw, xf || dn}));
      check("rnd.addr", 64'(bus.fp_addr), xf ? 64'(ta) : 64'h0);
      check("rnd.wd", 64'(bus.fp_wr_data), xf ? 64'(td) : 64'h0);
      check("rnd.rd0", 64'(bus.m0_rd_data), 64'(rd_exp[0]));
      check("rnd.rd1", 64'(bus.m1_rd_data), 64'(rd_exp[1]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
